// File: rtl/extmem_arbiter_if.sv
// Requester-side bus of the external-memory arbiter.
// Packed per-requester beat channel plus the shared read-response channel.
// master: a DMA engine / prefetcher side; slave: the arbiter.
interface extmem_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter sharing one external-memory port between N_REQ
// burst masters. A grant is held for a whole burst (until req_last);
// read data is steered back by a tag pipe matched to RD_LAT.
// Optional feature macro: EXTMEM_ARB_BURST_LIMIT_EN (force-release a grant
// after MAX_BURST beats and pulse burst_abort).
module extmem_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 256,
  localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  extmem_arbiter_if.slave   bus,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic [OW-1:0]     owner,
  output logic              burst_abort
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [OW-1:0]     last_owner;
  logic [OW-1:0]     pick;
  logic              pick_hit;
  logic              accept;
  logic              beat_we;
  logic              beat_last;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_wdata;
  logic              limit_hit;
  logic              release_grant;

  // Tag pipe: stage 0 is loaded on read acceptance, stage RD_LAT is the head.
  logic [RD_LAT:0]           tag_vld;
  logic [RD_LAT:0][OW-1:0]   tag_own;

  // Round-robin search starting one past the last owner.
  always_comb begin
    int unsigned   idx;
    logic [OW-1:0] cand;
    pick     = '0;
    pick_hit = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx  = (32'(last_owner) + i) % N_REQ;
      cand = OW'(idx);
      if (!pick_hit && bus.req_valid[cand]) begin
        pick     = cand;
        pick_hit = 1'b1;
      end
    end
  end

  // Select the owner's beat fields.
  always_comb begin
    accept     = (state == GRANT) && bus.req_valid[owner];
    beat_we    = bus.req_we[owner];
    beat_last  = bus.req_last[owner];
    beat_addr  = bus.req_addr[32'(owner)*ADDR_W +: ADDR_W];
    beat_wdata = bus.req_wdata[32'(owner)*DATA_W +: DATA_W];
  end

`ifdef EXTMEM_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  logic [CNT_W-1:0] beat_cnt;

  // The counter holds beats already accepted, so equality with MAX_BURST-1
  // marks the MAX_BURST-th beat as it is being accepted.
  assign limit_hit = accept && !beat_last && (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Count accepted beats within the current grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= release_grant ? '0 : beat_cnt + 1'b1;
    end
  end

  // One-cycle pulse when a grant is forcibly released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_abort <= 1'b0;
    end else begin
      burst_abort <= limit_hit;
    end
  end
`else
  assign limit_hit   = 1'b0;
  assign burst_abort = 1'b0;
`endif

  assign release_grant = accept && (beat_last || limit_hit);

  // FSM next state and combinational ready for the owner.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_hit) state_nxt = GRANT;
      end
      GRANT: begin
        bus.req_ready[owner] = 1'b1;
        if (release_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping: owner, busy and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= '0;
      busy       <= 1'b0;
      last_owner <= OW'(N_REQ - 1);
    end else begin
      if (state == IDLE && pick_hit) begin
        owner <= pick;
        busy  <= 1'b1;
      end
      if (release_grant) begin
        busy       <= 1'b0;
        last_owner <= owner;
      end
    end
  end

  // Registered memory strobes; addresses/data only update on a matching beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_we <= accept && beat_we;
      mem_re <= accept && !beat_we;
      if (accept && beat_we) begin
        mem_wr_addr <= beat_addr;
        mem_wr_data <= beat_wdata;
      end
      if (accept && !beat_we) begin
        mem_rd_addr <= beat_addr;
      end
    end
  end

  // Read tag pipe, independent of the FSM so in-flight reads survive a grant change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= {tag_vld[RD_LAT-1:0], accept && !beat_we};
      tag_own <= {tag_own[RD_LAT-1:0], owner};
    end
  end

  // Steer returning read data to the tagged requester.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (tag_vld[RD_LAT]) begin
      bus.rsp_valid[tag_own[RD_LAT]] = 1'b1;
      bus.rsp_rdata                  = mem_rd_data;
    end
  end

endmodule
